// File: rtl/embed_seq_ctrl_if.sv
// Memory/datapath bus of the watermark embedding sequencer.
// master = sequencer side, slave = subband memories plus embedding datapath.
interface embed_seq_ctrl_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 12
);
  // Strobes carry no backpressure: rd_en is a read the memories always honour,
  // returning ll*_rdata exactly one cycle later. wr_en is a write the output
  // memory always takes. Neither side ever stalls.
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      ll1_rdata;
  logic [N-1:0]      ll2_rdata;
  logic [N-1:0]      emb_ll1;
  logic [N-1:0]      emb_ll2;
  logic [N-1:0]      emb_alpha;
  logic [2*N-1:0]    emb_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2*N-1:0]    wr_data;

  modport master (
    output rd_en, rd_addr, emb_ll1, emb_ll2, emb_alpha, wr_en, wr_addr, wr_data,
    input  ll1_rdata, ll2_rdata, emb_out
  );

  modport slave (
    input  rd_en, rd_addr, emb_ll1, emb_ll2, emb_alpha, wr_en, wr_addr, wr_data,
    output ll1_rdata, ll2_rdata, emb_out
  );
endinterface

// File: rtl/embed_seq_ctrl.sv
// Sequencer streaming LL1/LL2 coefficient pairs through the embedding datapath.
// Define EMBED_CKSUM_EN to add the cksum output (running sum of written data).
module embed_seq_ctrl #(
  parameter int N      = 32,
  parameter int ADDR_W = 12,
  parameter int DP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N-1:0]      alpha_in,
  input  logic [ADDR_W:0]   num_coeff,
  output logic              busy,
  output logic              done,
  embed_seq_ctrl_if.master  bus,
  output logic [1:0]        o_dbg_state
`ifdef EMBED_CKSUM_EN
  , output logic [2*N-1:0]  cksum
`endif
);

  localparam int L = 3 + DP_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N-1:0]      r_alpha;
  logic [ADDR_W:0]   r_num;
  logic [ADDR_W-1:0] r_cnt;
  logic [L-1:0]      r_vld;
  logic [ADDR_W-1:0] r_addr [L];
  logic [N-1:0]      r_ll1;
  logic [N-1:0]      r_ll2;
  logic [2*N-1:0]    r_wr_data;
  logic              w_accept;
  logic              w_abort;
  logic              w_issue;
  logic              w_last;

  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_abort  = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_issue  = (r_state == S_RUN);
  assign w_last   = ({1'b0, r_cnt} == (r_num - (ADDR_W+1)'(1)));

  // A zero-count run spends one cycle in DRAIN (pipeline already empty) so
  // busy is visible for a cycle before the done pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (num_coeff == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (w_abort)     w_next = S_IDLE;
        else if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave when only the final write stage may still hold an entry, so
        // done lands in the cycle right after the last wr_en.
        if (w_abort)                  w_next = S_IDLE;
        else if (r_vld[L-2:0] == '0)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_alpha   <= '0;
      r_num     <= '0;
      r_cnt     <= '0;
      r_vld     <= '0;
      r_ll1     <= '0;
      r_ll2     <= '0;
      r_wr_data <= '0;
      for (int j = 0; j < L; j++) r_addr[j] <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_alpha <= alpha_in;
        r_num   <= num_coeff;
        r_cnt   <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
      if (w_abort) r_vld <= '0;
      else         r_vld <= {r_vld[L-2:0], w_issue};
      r_addr[0] <= r_cnt;
      for (int j = 1; j < L; j++) r_addr[j] <= r_addr[j-1];
      if (r_vld[0]) begin
        r_ll1 <= bus.ll1_rdata;
        r_ll2 <= bus.ll2_rdata;
      end
      if (r_vld[L-2]) r_wr_data <= bus.emb_out;
    end
  end

  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign o_dbg_state   = r_state;
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = r_cnt;
  assign bus.emb_ll1   = r_ll1;
  assign bus.emb_ll2   = r_ll2;
  assign bus.emb_alpha = r_alpha;
  assign bus.wr_en     = r_vld[L-1];
  assign bus.wr_addr   = r_addr[L-1];
  assign bus.wr_data   = r_wr_data;

`ifdef EMBED_CKSUM_EN
  logic [2*N-1:0] r_cksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cksum <= '0;
    else if (w_accept)   r_cksum <= '0;
    else if (r_vld[L-1]) r_cksum <= r_cksum + r_wr_data;
  end

  assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_embed_seq_ctrl.sv
// Bench for embed_seq_ctrl: a DP_LAT=0 and a DP_LAT=2 instance share stimulus;
// memory/datapath models, expected-write queues and a negedge monitor per instance.
module tb_embed_seq_ctrl;
  localparam int N  = 32;
  localparam int AW = 12;
  localparam int W  = AW + 2*N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  alpha_in = '0;
  logic [AW:0]   num_coeff = '0;
  logic          busy0, done0, busy2, done2;
  logic [1:0]    st0, st2;
`ifdef EMBED_CKSUM_EN
  logic [2*N-1:0] ck0, ck2;
  logic [2*N-1:0] exp_ck [2];
`endif

  embed_seq_ctrl_if #(.N(N), .ADDR_W(AW)) bus0 ();
  embed_seq_ctrl_if #(.N(N), .ADDR_W(AW)) bus2 ();

  embed_seq_ctrl #(.N(N), .ADDR_W(AW), .DP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .alpha_in(alpha_in),
    .num_coeff(num_coeff), .busy(busy0), .done(done0), .bus(bus0), .o_dbg_state(st0)
`ifdef EMBED_CKSUM_EN
    , .cksum(ck0)
`endif
  );

  embed_seq_ctrl #(.N(N), .ADDR_W(AW), .DP_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .alpha_in(alpha_in),
    .num_coeff(num_coeff), .busy(busy2), .done(done2), .bus(bus2), .o_dbg_state(st2)
`ifdef EMBED_CKSUM_EN
    , .cksum(ck2)
`endif
  );

  // ---------------- clock / models ----------------
  initial forever #5 clk = ~clk;

  logic [N-1:0]   ll1_mem [4096];
  logic [N-1:0]   ll2_mem [4096];
  logic [2*N-1:0] dp_s1, dp_s2;

  always @(posedge clk) begin
    if (bus0.rd_en) begin
      bus0.ll1_rdata <= ll1_mem[bus0.rd_addr];
      bus0.ll2_rdata <= ll2_mem[bus0.rd_addr];
    end
    if (bus2.rd_en) begin
      bus2.ll1_rdata <= ll1_mem[bus2.rd_addr];
      bus2.ll2_rdata <= ll2_mem[bus2.rd_addr];
    end
    dp_s1 <= 64'(bus2.emb_ll1) + 64'(bus2.emb_alpha) * 64'(bus2.emb_ll2);
    dp_s2 <= dp_s1;
  end

  assign bus0.emb_out = 64'(bus0.emb_ll1) + 64'(bus0.emb_alpha) * 64'(bus0.emb_ll2);
  assign bus2.emb_out = dp_s2;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q2[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_done_n = 0;
  int first_rd [2];
  int first_wr [2];
  int last_wr  [2];
  int wr_cnt   [2];
  int done_cnt [2];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_step(input int id, input logic rd_en, input logic wr_en,
                          input logic [AW-1:0] wr_addr, input logic [2*N-1:0] wr_data,
                          input logic done);
    logic [W-1:0] e;
    int qs;
    if (rd_en && first_rd[id] < 0) first_rd[id] = cyc;
    if (wr_en) begin
      if (wr_cnt[id] == 0) first_wr[id] = cyc;
      else check($sformatf("wr_gap%0d", id), cyc, last_wr[id] + 1);
      last_wr[id] = cyc;
      wr_cnt[id]++;
      qs = (id == 0) ? exp_q0.size() : exp_q2.size();
      if (qs == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wr%0d: actual addr=%0h data=%0h required no write", id, wr_addr, wr_data);
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q2.pop_front();
        check($sformatf("wr_addr%0d", id), wr_addr, e[W-1:2*N]);
        check($sformatf("wr_data%0d", id), wr_data, e[2*N-1:0]);
`ifdef EMBED_CKSUM_EN
        exp_ck[id] = exp_ck[id] + e[2*N-1:0];
`endif
      end
    end
    if (done) begin
      done_cnt[id]++;
      qs = (id == 0) ? exp_q0.size() : exp_q2.size();
      check($sformatf("done_q_empty%0d", id), qs, 0);
      if (wr_cnt[id] > 0) check($sformatf("done_after_wr%0d", id), cyc, last_wr[id] + 1);
`ifdef EMBED_CKSUM_EN
      check($sformatf("cksum%0d", id), (id == 0) ? ck0 : ck2, exp_ck[id]);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_step(0, bus0.rd_en, bus0.wr_en, bus0.wr_addr, bus0.wr_data, done0);
      mon_step(1, bus2.rd_en, bus2.wr_en, bus2.wr_addr, bus2.wr_data, done2);
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) begin
      ll1_mem[i] = $urandom;
      ll2_mem[i] = $urandom;
    end
  endtask

  // abort_after < 0: full run. Otherwise abort is driven in the cycle after
  // abort_after reads; only writes landing by that cycle (i + latency) survive.
  task automatic run(input logic [N-1:0] a, input logic [AW:0] n, input int abort_after);
    logic [2*N-1:0] d;
    for (int i = 0; i < int'(n); i++) begin
      d = 64'(ll1_mem[i]) + 64'(a) * 64'(ll2_mem[i]);
      if (abort_after < 0 || i + 3 <= abort_after) exp_q0.push_back({i[AW-1:0], d});
      if (abort_after < 0 || i + 5 <= abort_after) exp_q2.push_back({i[AW-1:0], d});
    end
    for (int k = 0; k < 2; k++) begin
      first_rd[k] = -1;
      wr_cnt[k]   = 0;
`ifdef EMBED_CKSUM_EN
      exp_ck[k]   = '0;
`endif
    end
    if (abort_after < 0) exp_done_n++;
    start     = 1'b1;
    alpha_in  = a;
    num_coeff = n;
    tick();
    start     = 1'b0;
    alpha_in  = $urandom;
    num_coeff = 13'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy0 || busy2 || done0 || done2) && t < 10000) begin
      tick();
      t++;
    end
    if (t >= 10000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: actual=still busy after %0d cycles required=idle", t);
    end
  endtask

  task automatic post_run(input int n);
    check("wr_count0", wr_cnt[0], n);
    check("wr_count2", wr_cnt[1], n);
    if (n > 0) begin
      check("latency0", first_wr[0] - first_rd[0], 3);
      check("latency2", first_wr[1] - first_rd[1], 5);
    end
  endtask

  initial begin
    int n;
    logic [N-1:0] a;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      wr_cnt[k]   = 0;
      first_rd[k] = -1;
    end
    fill_mem();
    tick(3);
    rst = 1'b0;
    check("rst_busy",  {busy0, busy2}, 2'b00);
    check("rst_done",  {done0, done2}, 2'b00);
    check("rst_rd_en", {bus0.rd_en, bus2.rd_en}, 2'b00);
    check("rst_wr_en", {bus0.wr_en, bus2.wr_en}, 2'b00);
    check("rst_wr_data", bus0.wr_data | bus2.wr_data, 0);
    check("rst_emb", {bus0.emb_ll1, bus0.emb_ll2, bus0.emb_alpha, bus0.wr_addr}, 0);
`ifdef EMBED_CKSUM_EN
    check("rst_cksum", ck0 | ck2, 0);
`endif
    tick(2);

    // Directed: small run with known values
    for (int i = 0; i < 4; i++) begin
      ll1_mem[i] = 32'(10 * (i + 1));
      ll2_mem[i] = 32'(i + 1);
    end
    run(32'd3, 13'd4, -1);
    wait_idle();
    post_run(4);
    tick(2);

    // Directed: all-ones operands, largest product
    ll1_mem[0] = 32'hFFFF_FFFF;
    ll2_mem[0] = 32'hFFFF_FFFF;
    run(32'hFFFF_FFFF, 13'd1, -1);
    wait_idle();
    post_run(1);
    tick(2);

    // Directed: zero-length run
    run(32'd7, 13'd0, -1);
    check("zero_busy", {busy0, busy2}, 2'b11);
    tick();
    check("zero_done", {done0, done2}, 2'b11);
    check("zero_busy_low", {busy0, busy2}, 2'b00);
    wait_idle();
    check("zero_rd_seen", {first_rd[0] >= 0, first_rd[1] >= 0}, 2'b00);
    post_run(0);
    tick(2);

    // Start pulse mid-run must be ignored
    fill_mem();
    run($urandom, 13'd8, -1);
    tick(3);
    start     = 1'b1;
    alpha_in  = 32'd5;
    num_coeff = 13'd5;
    tick();
    start = 1'b0;
    wait_idle();
    post_run(8);
    tick(2);

    // Abort after three reads, with a start in the abort cycle
    run($urandom, 13'd10, 3);
    tick(3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy",  {busy0, busy2}, 2'b00);
    check("abort_rd_en", {bus0.rd_en, bus2.rd_en}, 2'b00);
    tick(8);
    check("abort_idle", {busy0, busy2}, 2'b00);
    check("abort_q_empty", exp_q0.size() + exp_q2.size(), 0);
    run($urandom, 13'd6, -1);
    wait_idle();
    post_run(6);
    tick(2);

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      fill_mem();
      n = $urandom_range(1, 40);
      run($urandom, 13'(n), -1);
      wait_idle();
      post_run(n);
      tick($urandom_range(1, 3));
    end

    // Full address space: wrap only after the final issue
    fill_mem();
    run($urandom, 13'd4096, -1);
    wait_idle();
    post_run(4096);
    tick(2);

    // Asynchronous reset mid-run
    a = $urandom;
    run(a, 13'd20, -1);
    exp_done_n--;
    tick(6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  {busy0, busy2}, 2'b00);
    check("arst_strobes", {bus0.rd_en, bus2.rd_en, bus0.wr_en, bus2.wr_en}, 4'b0000);
    check("arst_wr_data", bus0.wr_data | bus2.wr_data, 0);
    check("arst_emb", {bus0.emb_ll1, bus2.emb_ll1, bus0.emb_alpha, bus2.emb_alpha}, 0);
`ifdef EMBED_CKSUM_EN
    check("arst_cksum", ck0 | ck2, 0);
`endif
    exp_q0.delete();
    exp_q2.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    run($urandom, 13'd5, -1);
    wait_idle();
    post_run(5);
    tick(3);

    check("done_count0", done_cnt[0], exp_done_n);
    check("done_count2", done_cnt[1], exp_done_n);
    check("final_q_empty", exp_q0.size() + exp_q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
